// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, the data port and the RAM-side bus of mem_arbiter.
// The slave modport is the arbiter's view; master is the view of the
// requesters plus the RAM (the side that drives requests and Dataout).
interface mem_arbiter_if;
    // instruction-fetch port
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        i_err;
    // data port
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_err;
    // RAM side
    logic [31:0] ram_address;
    logic [31:0] ram_writeData;
    logic        ram_RD;
    logic        ram_WR;
    logic [2:0]  ram_state;
    logic [31:0] ram_Dataout;
    // status
    logic        busy;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  ram_Dataout,
        output i_rdata, i_ack, i_err,
        output d_rdata, d_ack, d_err,
        output ram_address, ram_writeData, ram_RD, ram_WR, ram_state,
        output busy
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata,
        output ram_Dataout,
        input  i_rdata, i_ack, i_err,
        input  d_rdata, d_ack, d_err,
        input  ram_address, ram_writeData, ram_RD, ram_WR, ram_state,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter and sequencer for the shared big-endian
// 32-bit RAM. One access per 3 cycles: IDLE -> ACCESS -> RESP -> IDLE.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to alternate grants when
// both ports request together; without it the data port always wins.
module mem_arbiter #(
    parameter int unsigned ADDR_LIMIT  = 60,
    parameter logic [2:0]  WRITE_STATE = 3'b100
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        gnt_d_q, gnt_d_d;     // 1: data port owns the current access
    logic        err_q, err_d;
    logic [31:0] ram_address_q, ram_address_d;
    logic [31:0] ram_writeData_q, ram_writeData_d;
    logic        ram_rd_q, ram_rd_d;
    logic        ram_wr_q, ram_wr_d;
    logic [2:0]  ram_state_q, ram_state_d;
    logic        i_ack_q, i_ack_d;
    logic        i_err_q, i_err_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic        d_ack_q, d_ack_d;
    logic        d_err_q, d_err_d;
    logic [31:0] d_rdata_q, d_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic        rr_last_q, rr_last_d; // 1: last grant went to D, 0: to I
`endif

    // grant selection and the address check of the candidate request
    logic        pick_d;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [32:0] sel_end;
    logic        sel_err;

    // Choose the grantee in IDLE and flag misaligned / out-of-range words.
    // The end address is formed in 33 bits so addresses near 2^32 cannot wrap.
    always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        pick_d = bus.d_req && (!bus.i_req || !rr_last_q);
`else
        pick_d = bus.d_req;
`endif
        sel_we    = pick_d ? bus.d_we    : 1'b0;
        sel_addr  = pick_d ? bus.d_addr  : bus.i_addr;
        sel_wdata = pick_d ? bus.d_wdata : 32'h0;
        sel_end   = {1'b0, sel_addr} + 33'd3;
        sel_err   = (sel_addr[1:0] != 2'b00) || (sel_end > 33'(ADDR_LIMIT));
    end

    // Next-state logic. Every output is a flop; RAM strobes are set on the
    // grant edge so they are valid for exactly the ACCESS cycle, and the
    // ack/err/rdata flops are loaded on the closing ACCESS edge for RESP.
    always_comb begin
        state_d         = state_q;
        gnt_d_d         = gnt_d_q;
        err_d           = err_q;
        ram_address_d   = 32'h0;
        ram_writeData_d = 32'h0;
        ram_rd_d        = 1'b0;
        ram_wr_d        = 1'b0;
        ram_state_d     = 3'b000;
        i_ack_d         = 1'b0;
        i_err_d         = 1'b0;
        i_rdata_d       = 32'h0;
        d_ack_d         = 1'b0;
        d_err_d         = 1'b0;
        d_rdata_d       = 32'h0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        rr_last_d       = rr_last_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.d_req || bus.i_req) begin
                    state_d         = ACCESS;
                    gnt_d_d         = pick_d;
                    err_d           = sel_err;
                    ram_address_d   = sel_addr;
                    ram_writeData_d = sel_wdata;
                    ram_rd_d        = !sel_we && !sel_err;
                    ram_wr_d        = sel_we && !sel_err;
                    ram_state_d     = (sel_we && !sel_err) ? WRITE_STATE : 3'b000;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    rr_last_d       = pick_d;
`endif
                end
            end
            ACCESS: begin
                // RD is only ever high for a legal read, so it doubles as the
                // capture enable; writes and errors return zero.
                state_d = RESP;
                if (gnt_d_q) begin
                    d_ack_d   = 1'b1;
                    d_err_d   = err_q;
                    d_rdata_d = ram_rd_q ? bus.ram_Dataout : 32'h0;
                end else begin
                    i_ack_d   = 1'b1;
                    i_err_d   = err_q;
                    i_rdata_d = ram_rd_q ? bus.ram_Dataout : 32'h0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything at once, which
    // also drops ram_WR before the RAM's commit edge in an aborted write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            gnt_d_q         <= 1'b0;
            err_q           <= 1'b0;
            ram_address_q   <= 32'h0;
            ram_writeData_q <= 32'h0;
            ram_rd_q        <= 1'b0;
            ram_wr_q        <= 1'b0;
            ram_state_q     <= 3'b000;
            i_ack_q         <= 1'b0;
            i_err_q         <= 1'b0;
            i_rdata_q       <= 32'h0;
            d_ack_q         <= 1'b0;
            d_err_q         <= 1'b0;
            d_rdata_q       <= 32'h0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_last_q       <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            gnt_d_q         <= gnt_d_d;
            err_q           <= err_d;
            ram_address_q   <= ram_address_d;
            ram_writeData_q <= ram_writeData_d;
            ram_rd_q        <= ram_rd_d;
            ram_wr_q        <= ram_wr_d;
            ram_state_q     <= ram_state_d;
            i_ack_q         <= i_ack_d;
            i_err_q         <= i_err_d;
            i_rdata_q       <= i_rdata_d;
            d_ack_q         <= d_ack_d;
            d_err_q         <= d_err_d;
            d_rdata_q       <= d_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_last_q       <= rr_last_d;
`endif
        end
    end

    // drive the bus from the registers
    always_comb begin
        bus.ram_address   = ram_address_q;
        bus.ram_writeData = ram_writeData_q;
        bus.ram_RD        = ram_rd_q;
        bus.ram_WR        = ram_wr_q;
        bus.ram_state     = ram_state_q;
        bus.i_ack         = i_ack_q;
        bus.i_err         = i_err_q;
        bus.i_rdata       = i_rdata_q;
        bus.d_ack         = d_ack_q;
        bus.d_err         = d_err_q;
        bus.d_rdata       = d_rdata_q;
        bus.busy          = (state_q != IDLE);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a byte-array RAM model, a shadow
// memory holding what the RAM should contain, and a per-transaction schedule
// (ACCESS / RESP / IDLE slots, 3 cycles per grant) derived from the rules.
module tb_mem_arbiter;

    localparam int LIMIT = 60;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0] mem [0:63];   // RAM model contents
    logic [7:0] sh  [0:63];   // expected RAM contents
    bit         rr_last_m;    // 1: last grant to D (used with round robin)

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // RAM: combinational big-endian read, commit on negedge in write state
    always_comb begin
        if (bus.ram_address <= 32'd60)
            bus.ram_Dataout = {mem[bus.ram_address[5:0]], mem[bus.ram_address[5:0] + 6'd1],
                               mem[bus.ram_address[5:0] + 6'd2], mem[bus.ram_address[5:0] + 6'd3]};
        else
            bus.ram_Dataout = 32'h0;
    end

    always @(negedge clk) begin
        if (bus.ram_WR && bus.ram_state == 3'b100 && bus.ram_address <= 32'd60) begin
            mem[bus.ram_address[5:0]]        <= bus.ram_writeData[31:24];
            mem[bus.ram_address[5:0] + 6'd1] <= bus.ram_writeData[23:16];
            mem[bus.ram_address[5:0] + 6'd2] <= bus.ram_writeData[15:8];
            mem[bus.ram_address[5:0] + 6'd3] <= bus.ram_writeData[7:0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit err_of(input logic [31:0] a);
        return (a % 4 != 0) || (longint'(a) + 3 > LIMIT);
    endfunction

    function automatic logic [31:0] sh_word(input logic [31:0] a);
        int b;
        b = int'(a);
        return {sh[b], sh[b+1], sh[b+2], sh[b+3]};
    endfunction

    task automatic sh_put(input int a, input logic [31:0] w);
        sh[a] = w[31:24]; sh[a+1] = w[23:16]; sh[a+2] = w[15:8]; sh[a+3] = w[7:0];
        mem[a] = w[31:24]; mem[a+1] = w[23:16]; mem[a+2] = w[15:8]; mem[a+3] = w[7:0];
    endtask

    // One transaction (or a pair when both ports request). Ports: 0 = D, 1 = I.
    // Each grant occupies three slots: ACCESS, RESP (ack), IDLE.
    task automatic run(input bit dv, input bit dwe, input logic [31:0] da, input logic [31:0] dw,
                       input bit iv, input logic [31:0] ia);
        bit          we_p  [2];
        bit          err_p [2];
        logic [31:0] adr_p [2];
        logic [31:0] dat_p [2];
        logic [31:0] exp_rd;
        int          first, p, ph, total;
        we_p[0] = dwe;  adr_p[0] = da; dat_p[0] = dw; err_p[0] = err_of(da);
        we_p[1] = 1'b0; adr_p[1] = ia; dat_p[1] = 0;  err_p[1] = err_of(ia);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        first = (dv && iv) ? (rr_last_m ? 1 : 0) : (dv ? 0 : 1);
`else
        first = dv ? 0 : 1;
`endif
        total  = (dv && iv) ? 6 : 3;
        exp_rd = 0;
        bus.d_req = dv; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = dw;
        bus.i_req = iv; bus.i_addr = ia;
        for (int t = 1; t <= total; t++) begin
            tick();
            p  = (t <= 3) ? first : 1 - first;
            ph = (t - 1) % 3;
            chk("busy", 32'(bus.busy), 32'(ph != 2));
            if (ph == 0) begin
                rr_last_m = (p == 0);
                chk("ram_RD", 32'(bus.ram_RD), 32'(!we_p[p] && !err_p[p]));
                chk("ram_WR", 32'(bus.ram_WR), 32'(we_p[p] && !err_p[p]));
                chk("ram_state", 32'(bus.ram_state), (we_p[p] && !err_p[p]) ? 32'd4 : 32'd0);
                if (!err_p[p]) chk("ram_address", bus.ram_address, adr_p[p]);
                if (we_p[p] && !err_p[p]) begin
                    chk("ram_writeData", bus.ram_writeData, dat_p[p]);
                    sh_put_shadow_only(adr_p[p], dat_p[p]);
                    exp_rd = 0;
                end else begin
                    exp_rd = err_p[p] ? 32'h0 : sh_word(adr_p[p]);
                end
            end else if (ph == 1) begin
                chk("d_ack", 32'(bus.d_ack), 32'(p == 0));
                chk("i_ack", 32'(bus.i_ack), 32'(p == 1));
                if (p == 0) begin
                    chk("d_err", 32'(bus.d_err), 32'(err_p[0]));
                    chk("d_rdata", bus.d_rdata, exp_rd);
                    bus.d_req = 1'b0;
                end else begin
                    chk("i_err", 32'(bus.i_err), 32'(err_p[1]));
                    chk("i_rdata", bus.i_rdata, exp_rd);
                    bus.i_req = 1'b0;
                end
            end else begin
                chk("acks_idle", {30'h0, bus.d_ack, bus.i_ack}, 32'h0);
                chk("rdata_idle", bus.d_rdata | bus.i_rdata, 32'h0);
            end
        end
    endtask

    task automatic sh_put_shadow_only(input logic [31:0] a, input logic [31:0] w);
        int b;
        b = int'(a);
        sh[b] = w[31:24]; sh[b+1] = w[23:16]; sh[b+2] = w[15:8]; sh[b+3] = w[7:0];
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'($urandom_range(0, 63));
        if (r == 1) return 32'hFFFF_FFFC;
        if (r == 2) return ($urandom_range(0, 1) != 0) ? 32'd60 : 32'd64;
        return 32'($urandom_range(0, 14) * 4);
    endfunction

    initial begin
        logic [31:0] w12, w16;
        int kind;
        for (int k = 0; k < 64; k++) begin mem[k] = 8'h00; sh[k] = 8'h00; end
        rr_last_m = 1'b0;
        bus.i_req = 0; bus.i_addr = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
        reset = 1'b1;
        #2;
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_ram_addr", bus.ram_address, 32'h0);
        chk("rst_ram_wd", bus.ram_writeData, 32'h0);
        chk("rst_ram_ctl", {27'h0, bus.ram_state, bus.ram_RD, bus.ram_WR}, 32'h0);
        chk("rst_acks", {28'h0, bus.d_ack, bus.d_err, bus.i_ack, bus.i_err}, 32'h0);
        chk("rst_rdata", bus.d_rdata | bus.i_rdata, 32'h0);
        #10 reset = 1'b0;
        tick();

        // write then read on D
        run(1, 1, 32'd8, 32'h11223344, 0, 0);
        #4; // past the commit negedge already; RAM bytes must hold the word
        chk("mem8_11", {mem[8], mem[9], mem[10], mem[11]}, 32'h11223344);
        run(1, 0, 32'd8, 0, 0, 0);

        // fetch of a preloaded word
        sh_put(4, 32'hDEADBEEF);
        run(0, 0, 0, 0, 1, 32'd4);

        // errors: misaligned write, out-of-range fetch, huge address
        run(1, 1, 32'd6, 32'hCAFEF00D, 0, 0);
        run(0, 0, 0, 0, 1, 32'd60);
        run(1, 0, 32'hFFFF_FFFC, 0, 0, 0);
        run(1, 0, 32'd56, 0, 0, 0);

        // contention
        run(1, 0, 32'd8, 0, 1, 32'd4);
        run(1, 1, 32'd4, 32'h0BADCAFE, 1, 32'd4);

        // reset in the first half of an ACCESS write
        sh_put(0, 32'h01020304);
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 0; bus.d_wdata = 32'hAAAAAAAA;
        tick();
        chk("abort_wr_on", 32'(bus.ram_WR), 32'h1);
        reset = 1'b1;
        bus.d_req = 0;
        #1;
        chk("abort_wr_off", 32'(bus.ram_WR), 32'h0);
        chk("abort_busy", 32'(bus.busy), 32'h0);
        chk("abort_ram_addr", bus.ram_address, 32'h0);
        chk("abort_ram_ctl", {29'h0, bus.ram_state}, 32'h0);
        #1 reset = 1'b0;
        rr_last_m = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("abort_no_ack", {30'h0, bus.d_ack, bus.i_ack}, 32'h0);
        end
        chk("abort_mem", {mem[0], mem[1], mem[2], mem[3]}, 32'h01020304);

        // inputs changed after the grant are ignored; held req re-requests
        w12 = $urandom; w16 = $urandom;
        sh_put(12, w12); sh_put(16, w16);
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'd12;
        tick();
        chk("hold_addr12", bus.ram_address, 32'd12);
        bus.d_addr = 32'd16;
        tick();
        chk("hold_ack1", 32'(bus.d_ack), 32'h1);
        chk("hold_rd12", bus.d_rdata, w12);
        tick();
        chk("hold_gap", 32'(bus.d_ack), 32'h0);
        tick();
        chk("hold_addr16", bus.ram_address, 32'd16);
        tick();
        chk("hold_ack2", 32'(bus.d_ack), 32'h1);
        chk("hold_rd16", bus.d_rdata, w16);
        rr_last_m = 1'b1;
        bus.d_req = 0;
        tick();

        // randomized traffic against the schedule/shadow model
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 2);
            run(kind != 1, $urandom_range(0, 1) != 0, rand_addr(), $urandom,
                kind != 0, rand_addr());
        end
        for (int k = 0; k < 64; k++) chk("final_mem", 32'(mem[k]), 32'(sh[k]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // absolute time limit so the bench always ends
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
